// File: rtl/freelist_if.sv
// freelist_if: rename-side alloc/commit/status bundle for the free list.
// FREELIST_CKPT_EN adds the snapshot and branch-kill signals.
interface freelist_if #(
  parameter int WIDTH_REG = 7
`ifdef FREELIST_CKPT_EN
  , parameter int WIDTH_BRM = 4
`endif
);
  logic [4*WIDTH_REG-1:0] com_prd4x;
  logic [3:0] com_en;
  logic [2:0] alloc_n;
  logic [4*WIDTH_REG-1:0] prd4x;
  logic ready;
  logic [WIDTH_REG:0] count;
  logic overflow;
`ifdef FREELIST_CKPT_EN
  logic snap_we;
  logic [WIDTH_BRM-1:0] snap_id;
  logic [2**WIDTH_BRM-1:0] brkill;
  modport master (output com_prd4x, com_en, alloc_n, snap_we, snap_id, brkill,
                  input prd4x, ready, count, overflow);
  modport slave (input com_prd4x, com_en, alloc_n, snap_we, snap_id, brkill,
                 output prd4x, ready, count, overflow);
`else
  modport master (output com_prd4x, com_en, alloc_n, input prd4x, ready, count, overflow);
  modport slave (input com_prd4x, com_en, alloc_n, output prd4x, ready, count, overflow);
`endif
endinterface

// File: rtl/freelist.sv
// freelist: rename-stage physical register free list, 4-wide pop and compacted 4-wide push.
// Define FREELIST_CKPT_EN for per-branch head checkpoints with rollback on kill.
module freelist #(
  parameter int WIDTH_REG = 7
`ifdef FREELIST_CKPT_EN
  , parameter int WIDTH_BRM = 4
`endif
  , parameter int NARCH = 32
) (
  input logic i_clk,
  input logic i_rst_n,
  freelist_if.slave fl
);
  localparam int NPREG = 2**WIDTH_REG;
  localparam int PW = WIDTH_REG + 1;
  typedef logic [PW-1:0] ptr_t;
  logic [WIDTH_REG-1:0] fbuf [NPREG];
  ptr_t head, tail, count, alloc, pop, head_nx, occ, room, npush, tail_nx;
  ptr_t off [4];
  logic kill, pop_err, push_err, ovf;
  assign count = tail - head;
  assign alloc = ptr_t'(fl.alloc_n);
  assign pop = alloc > count ? count : alloc;
  assign npush = ptr_t'($countones(fl.com_en));
  always_comb
    for (int k = 0; k < 4; k++) off[k] = ptr_t'($countones(fl.com_en & 4'((1 << k) - 1)));
`ifdef FREELIST_CKPT_EN
  localparam int NCKPT = 2**WIDTH_BRM;
  ptr_t ckpt [NCKPT];
  logic [WIDTH_BRM-1:0] kid;
  assign kill = |fl.brkill;
  always_comb begin
    kid = '0;
    for (int k = NCKPT - 1; k >= 0; k--) kid = fl.brkill[k] ? WIDTH_BRM'(k) : kid;
  end
  assign head_nx = kill ? ckpt[kid] : head + pop;
  // A kill on the slot being snapped this cycle wins over the snapshot
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)
      for (int i = 0; i < NCKPT; i++) ckpt[i] <= '0;
    else if (fl.snap_we && !(kill && fl.snap_id == kid))
      ckpt[fl.snap_id] <= head + alloc;
`else
  assign kill = 1'b0;
  assign head_nx = head + pop;
`endif
  assign pop_err = !kill && alloc > count;
  // Room is measured against the post-pop head so a full list can push while popping
  assign occ = tail - head_nx;
  assign room = occ >= ptr_t'(NPREG - 1) ? '0 : ptr_t'(NPREG - 1) - occ;
  assign push_err = npush > room;
  assign tail_nx = tail + (push_err ? room : npush);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      for (int i = 0; i < NPREG; i++) fbuf[i] <= i < NPREG - NARCH ? WIDTH_REG'(NARCH + i) : '0;
      head <= '0;
      tail <= ptr_t'(NPREG - NARCH);
      ovf <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (fl.com_en[k] && off[k] < room)
          fbuf[WIDTH_REG'(tail + off[k])] <= fl.com_prd4x[k*WIDTH_REG +: WIDTH_REG];
      head <= head_nx;
      tail <= tail_nx;
      ovf <= ovf | pop_err | push_err;
    end
  always_comb begin
    fl.prd4x = '0;
    for (int k = 0; k < 4; k++) fl.prd4x[k*WIDTH_REG +: WIDTH_REG] = fbuf[WIDTH_REG'(head + ptr_t'(k))];
  end
  assign fl.ready = count >= ptr_t'(4);
  assign fl.count = count;
  assign fl.overflow = ovf;
endmodule

// File: tb/tb_freelist.sv
// tb_freelist: directed stimulus for freelist checked against a queue model of the free list.
// Define FREELIST_CKPT_EN to also exercise checkpoint/kill rollback.
module tb_freelist;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  freelist_if fi ();
  freelist dut (.i_clk(clk), .i_rst_n(rst_n), .fl(fi.slave));
  int vecs = 0;
  int miss = 0;
  int m_q[$];
  int m_ovf;
`ifdef FREELIST_CKPT_EN
  int sv [16][$];
`endif

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] lane(input int k);
    return 32'(fi.prd4x[k*7 +: 7]);
  endfunction

  task automatic idle();
    fi.alloc_n = '0;
    fi.com_en = '0;
    fi.com_prd4x = '0;
`ifdef FREELIST_CKPT_EN
    fi.snap_we = 1'b0;
    fi.snap_id = '0;
    fi.brkill = '0;
`endif
  endtask

  task automatic model_reset();
    m_q = {};
    for (int i = 0; i < 96; i++) m_q.push_back(32 + i);
    m_ovf = 0;
`ifdef FREELIST_CKPT_EN
    for (int i = 0; i < 16; i++) sv[i] = m_q;
`endif
  endtask

  // Free list as an ordered queue; a checkpoint is a saved copy that keeps collecting later pushes
  task automatic model_step();
    int pv[$];
    int n;
    int kid;
    kid = -1;
    for (int k = 0; k < 4; k++) if (fi.com_en[k]) pv.push_back(int'(fi.com_prd4x[k*7 +: 7]));
`ifdef FREELIST_CKPT_EN
    for (int i = 15; i >= 0; i--) if (fi.brkill[i]) kid = i;
    for (int i = 0; i < 16; i++) foreach (pv[j]) sv[i].push_back(pv[j]);
    if (kid >= 0) m_q = sv[kid];
`endif
    if (kid < 0) begin
      n = int'(fi.alloc_n);
      if (n > m_q.size()) begin
        m_ovf = 1;
        n = m_q.size();
      end
      repeat (n) void'(m_q.pop_front());
      foreach (pv[j]) if (m_q.size() < 127) m_q.push_back(pv[j]); else m_ovf = 1;
    end
`ifdef FREELIST_CKPT_EN
    if (fi.snap_we && kid != int'(fi.snap_id)) sv[fi.snap_id] = m_q;
`endif
  endtask

  task automatic compare_model();
    chk("count", 32'(fi.count), m_q.size());
    chk("ready", 32'(fi.ready), 32'(m_q.size() >= 4));
    chk("overflow", 32'(fi.overflow), m_ovf);
    for (int k = 0; k < 4 && k < m_q.size(); k++) chk($sformatf("lane%0d", k), lane(k), m_q[k]);
  endtask

  task automatic tick(input int a, input logic [3:0] en, input int p0 = 0, input int p1 = 0,
                      input int p2 = 0, input int p3 = 0);
    fi.alloc_n = 3'(a);
    fi.com_en = en;
    fi.com_prd4x = {7'(p3), 7'(p2), 7'(p1), 7'(p0)};
    @(posedge clk);
    model_step();
    #1 idle();
    @(negedge clk);
    compare_model();
  endtask

  // Holds reset across a rising edge with whatever inputs are currently driven
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 idle();
    rst_n = 1'b1;
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    idle();
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compare_model();
    chk("rst_count", 32'(fi.count), 96);
    chk("rst_lane0", lane(0), 32);
    chk("rst_lane3", lane(3), 35);
    chk("rst_ready", 32'(fi.ready), 1);
    chk("rst_ovf", 32'(fi.overflow), 0);
    tick(4, 4'b1111, 10, 11, 12, 13);
    chk("pushpop_count", 32'(fi.count), 96);
    chk("pushpop_lane0", lane(0), 36);
    tick(0, 4'b1010, 0, 5, 0, 9);
    chk("compact_count", 32'(fi.count), 98);
    tick(3, 4'b0000);
    chk("pop3_count", 32'(fi.count), 95);
    chk("pop3_lane0", lane(0), 39);
    repeat (22) tick(4, 4'b0000);
    tick(1, 4'b0000);
    chk("drain_lane0", lane(0), 10);
    chk("drain_lane3", lane(3), 13);
    chk("drain_count", 32'(fi.count), 6);
    tick(4, 4'b0000);
    chk("compact_lane0", lane(0), 5);
    chk("compact_lane1", lane(1), 9);
    chk("low_ready", 32'(fi.ready), 0);
    tick(3, 4'b0000);
    chk("under_ovf", 32'(fi.overflow), 1);
    chk("under_count", 32'(fi.count), 0);
    for (int i = 0; i < 6; i++) tick(0, 4'b1111, 40 + 4*i, 41 + 4*i, 42 + 4*i, 43 + 4*i);
    tick(0, 4'b1111, 100, 101, 102, 103);
    repeat (6) tick(4, 4'b0000);
    chk("wrap_count", 32'(fi.count), 4);
    chk("wrap_lane0", lane(0), 100);
    chk("wrap_lane3", lane(3), 103);
    fi.alloc_n = 3'd4;
    fi.com_en = 4'b1111;
    fi.com_prd4x = '1;
    do_reset();
    chk("midrst_count", 32'(fi.count), 96);
    chk("midrst_lane0", lane(0), 32);
    chk("midrst_ovf", 32'(fi.overflow), 0);
    repeat (7) tick(0, 4'b1111, 1, 2, 3, 4);
    tick(0, 4'b1111, 5, 6, 7, 8);
    chk("full_count", 32'(fi.count), 127);
    chk("full_ovf", 32'(fi.overflow), 1);
    repeat (31) tick(4, 4'b0000);
    chk("drop_count", 32'(fi.count), 3);
    chk("drop_lane0", lane(0), 5);
    chk("drop_lane2", lane(2), 7);
`ifdef FREELIST_CKPT_EN
    do_reset();
    fi.snap_we = 1'b1;
    fi.snap_id = 4'd2;
    tick(1, 4'b0000);
    chk("snap_lane0", lane(0), 33);
    tick(4, 4'b0000);
    tick(2, 4'b0000);
    chk("spec_count", 32'(fi.count), 89);
    fi.brkill = 16'h0004;
    tick(3, 4'b0001, 77);
    chk("kill_lane0", lane(0), 33);
    chk("kill_count", 32'(fi.count), 96);
    chk("kill_ovf", 32'(fi.overflow), 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/freelist.md
# freelist

Physical-register free list for the rename stage. Pops up to four free physical register numbers per cycle for newly dispatched instructions. Pushes back up to four registers per cycle from the reorder-buffer commit port (`com_prd4x` / `com_en`). Optionally checkpoints its read pointer per branch mask bit so it can roll back on a branch kill.

## Interface
- `WIDTH_REG`, 7 — physical register number width; `NPREG = 2**WIDTH_REG`.
- `WIDTH_BRM`, 4 — branch tag width; `NCKPT = 2**WIDTH_BRM` checkpoint slots.
- `NARCH`, 32 — architectural registers; physical regs `0..NARCH-1` are mapped at reset.

Ports:
- `i_clk` — input, 1 — clock; all state updates on the rising edge.
- `i_rst_n` — input, 1 — asynchronous, active-low reset.
- `i_com_prd4x` — input, 4*WIDTH_REG — freed registers; lane k is bits `[(k+1)*WIDTH_REG-1 : k*WIDTH_REG]`.
- `i_com_en` — input, 4 — per-lane free valid.
- `i_alloc_n` — input, 3 — number of registers consumed this cycle, 0..4.
- `o_prd4x` — output, 4*WIDTH_REG — offered registers; lane k = entry `head+k`.
- `o_ready` — output, 1 — at least 4 entries are free.
- `o_count` — output, WIDTH_REG+1 — free-entry count.
- `o_overflow` — output, 1 — sticky error flag.
- `i_snap_we` — input, 1 — take a checkpoint (only with `FREELIST_CKPT_EN`).
- `i_snap_id` — input, WIDTH_BRM — checkpoint slot (only with `FREELIST_CKPT_EN`).
- `i_brkill` — input, NCKPT — one-hot kill; restore from the set bit (only with `FREELIST_CKPT_EN`).

## Operation
- Storage: circular buffer of `NPREG` entries × WIDTH_REG bits.
- Pointers: `head` and `tail` are each WIDTH_REG+1 bits, with an extra wrap bit.
- `count = tail - head`, computed modulo 2**(WIDTH_REG+1).
- Reset values:
  - `buf[i] = NARCH + i` for i < NPREG-NARCH; other entries are 0.
  - `head = 0`, `tail = NPREG-NARCH` (96 at defaults).
  - `o_overflow = 0`; all checkpoints = 0.
- Pop:
  - `head <= head + i_alloc_n`.
  - `i_alloc_n > count` is illegal. When it occurs, clamp the pop to `count` and set `o_overflow`.
  - `o_ready = (count >= 4)`.
  - Lanes beyond `count` present stale data.
- Push:
  - Enabled lanes are compacted in ascending lane order.
  - The j-th enabled lane is written to `buf[tail+j]`.
  - `tail <= tail + popcount(i_com_en)`.
  - Lanes carrying register 0 are pushed as given; no filtering is done.
- Push beyond capacity (count after update > NPREG-1) sets `o_overflow`. Excess entries are dropped and `tail` saturates at `head+NPREG-1`.
- Simultaneous push and pop are independent. Count after the edge = `count + pushes - pops`.
- Wrap-around: indices are taken modulo NPREG. Wrap-bit toggling is transparent.

## Timing
- `o_prd4x`, `o_ready` and `o_count` are combinational from registered state. Zero-latency offer.
- Pushed registers become visible to pop one cycle after the push edge. There is no same-cycle bypass.
- A pop acknowledged in cycle N removes the entries at edge N. `o_prd4x` shifts in cycle N+1.
- Reset asserted mid-operation immediately restores reset values, discarding in-flight pushes and pops.

## Configuration
- `FREELIST_CKPT_EN` defined:
  - `i_snap_we` stores `head + i_alloc_n` (the post-pop head) into `ckpt[i_snap_id]`.
  - A nonzero `i_brkill` sets `head <= ckpt[k]`, where k is the index of the set bit. That cycle's pop is ignored; push still applies.
  - If kill and snap target the same slot in the same cycle, the kill wins and the snapshot is not written.
  - With multiple kill bits set, the lowest index is used.
- `FREELIST_CKPT_EN` undefined:
  - Checkpoint ports are absent.
  - No checkpoint storage exists.
  - `head` is changed only by pops.

## Test plan
- Reset:
  - Release `i_rst_n` → `o_count=96`, `o_prd4x={35,34,33,32}`, `o_ready=1`, `o_overflow=0`.
- Pop:
  - `i_alloc_n=3` for one cycle → next cycle `o_prd4x` lane0=35, `o_count=93`.
- Compacted push:
  - `i_com_en=4'b1010`, lanes 1/3 = 5/9 → `buf[96]=5`, `buf[97]=9`, `o_count=98`.
  - Drain 96 entries → `o_prd4x` lane0=5, lane1=9.
- Simultaneous push and pop:
  - `i_alloc_n=4` with `i_com_en=4'b1111` → count unchanged at 96.
  - Freed registers appear only after the prior 96 entries.
- Wrap and empty:
  - Pop until `o_count=2` → `o_ready=0`.
  - `i_alloc_n=3` → `o_overflow=1`, `o_count=0`.
  - Push 4 across the index-127→0 boundary → correct order is returned.
- Checkpoint (`FREELIST_CKPT_EN`):
  - Snap id 2 with `i_alloc_n=1` → ckpt = head+1.
  - Pop 6 more; kill `i_brkill=1<<2` while pushing 1 → head restored, `o_prd4x` lane0 = 33.
  - `o_count` = 96 - 1 + 1 = 96.
